// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake bundle for the iterative binary-to-BCD converter.
// The master drives the request and operand; the slave returns status and result.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Optional leading-zero blanking (digits above the top nonzero one become 4'hF) when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bin2bcd_seq_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digitsCheck
        $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [WIDTH-1:0]  r_shiftReg;
    logic [BW-1:0]     r_scratch;
    logic [CW-1:0]     r_count;
    logic [BW-1:0]     r_bcd;
    logic              r_done;

    logic              w_busy;
    logic              w_capture;
    logic              w_shiftEn;
    logic              w_lastShift;
    logic [BW-1:0]     w_adjusted;
    logic [BW-1:0]     w_scratchNext;
    logic [WIDTH-1:0]  w_shiftNext;
    logic [BW-1:0]     w_loadValue;

    assign w_lastShift = (r_count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start)   w_nextState = SHIFT;
            SHIFT:   if (w_lastShift) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state == SHIFT);
        w_capture = (r_state == IDLE) && bus.start;
        w_shiftEn = (r_state == SHIFT);
    end

    // Add-3 correction happens before the shift so each digit stays 0..9 after doubling.
    always_comb begin
        w_adjusted = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adjusted[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_scratchNext = {w_adjusted[BW-2:0], r_shiftReg[WIDTH-1]};
    assign w_shiftNext   = r_shiftReg << 1;

`ifdef BIN2BCD_BLANK_EN
    logic w_seenNonZero;

    // Scan from the top digit down; digit 0 is always shown so zero reads as "0".
    always_comb begin
        w_loadValue   = w_scratchNext;
        w_seenNonZero = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_scratchNext[4*i +: 4] != 4'd0) begin
                w_seenNonZero = 1'b1;
            end
            if (!w_seenNonZero) begin
                w_loadValue[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign w_loadValue = w_scratchNext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shiftReg <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_bcd      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_shiftReg <= bus.bin;
                r_scratch  <= '0;
                r_count    <= CW'(WIDTH);
            end else if (w_shiftEn) begin
                r_shiftReg <= w_shiftNext;
                r_scratch  <= w_scratchNext;
                r_count    <= r_count - CW'(1);
                if (w_lastShift) begin
                    r_bcd  <= w_loadValue;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard testbench for bin2bcd_seq (WIDTH=8, DIGITS=3); expected digits come from a divide-by-ten model.
// Honours BIN2BCD_BLANK_EN the same way the design does, so both build variants are covered.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LIMIT  = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    logic [11:0] expQ[$];

    function automatic logic [11:0] refBcd(input int v);
        logic [11:0] r;
        int d0, d1, d2;
        d0 = v % 10;
        d1 = (v / 10) % 10;
        d2 = v / 100;
        r  = {4'(d2), 4'(d1), 4'(d0)};
`ifdef BIN2BCD_BLANK_EN
        if (d2 == 0) begin
            r[11:8] = 4'hF;
            if (d1 == 0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic test_reset;
        bus.start = 1'b0;
        bus.bin   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else nPass++;
        nChecks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else nPass++;
        nChecks++;
        if (bus.bcd !== 12'h000) $display("[TB] FAIL reset_bcd: got %h expected 000", bus.bcd); else nPass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", bus.busy); else nPass++;
    endtask

    task automatic test_values;
        int vals[4] = '{255, 0, 7, 40};
        int cycles;
        int busyCycles;
        logic [11:0] exp;
        foreach (vals[k]) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.bin   = 8'(vals[k]);
            expQ.push_back(refBcd(vals[k]));
            @(negedge clk);
            bus.start  = 1'b0;
            bus.bin    = 8'hAA;
            cycles     = 0;
            busyCycles = 0;
            while (bus.done !== 1'b1 && cycles < LIMIT) begin
                if (bus.busy === 1'b1) busyCycles++;
                @(negedge clk);
                cycles++;
            end
            exp = expQ.pop_front();
            nChecks++;
            if (cycles >= LIMIT) begin
                $display("[TB] FAIL value_timeout: bin=%0d got no done expected done within %0d cycles", vals[k], LIMIT);
            end else begin
                nPass++;
                nChecks++;
                if (cycles != WIDTH) $display("[TB] FAIL value_latency: bin=%0d got %0d expected %0d", vals[k], cycles, WIDTH); else nPass++;
                nChecks++;
                if (busyCycles != WIDTH) $display("[TB] FAIL value_busy_cycles: bin=%0d got %0d expected %0d", vals[k], busyCycles, WIDTH); else nPass++;
                nChecks++;
                if (bus.busy !== 1'b0) $display("[TB] FAIL value_busy_at_done: bin=%0d got %b expected 0", vals[k], bus.busy); else nPass++;
                nChecks++;
                if (bus.bcd !== exp) $display("[TB] FAIL value_bcd: bin=%0d got %h expected %h", vals[k], bus.bcd, exp); else nPass++;
                @(negedge clk);
                nChecks++;
                if (bus.done !== 1'b0) $display("[TB] FAIL value_done_pulse: bin=%0d got %b expected 0", vals[k], bus.done); else nPass++;
                nChecks++;
                if (bus.bcd !== exp) $display("[TB] FAIL value_bcd_hold: bin=%0d got %h expected %h", vals[k], bus.bcd, exp); else nPass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        int doneCount;
        logic [11:0] exp;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd99;
        expQ.push_back(refBcd(99));
        @(negedge clk);
        bus.bin   = 8'd100;
        cycles    = 0;
        while (bus.done !== 1'b1 && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        exp = expQ.pop_front();
        nChecks++;
        if (bus.bcd !== exp || cycles >= LIMIT) $display("[TB] FAIL b2b_first_bcd: got %h expected %h", bus.bcd, exp); else nPass++;
        expQ.push_back(refBcd(100));
        @(negedge clk);
        bus.start = 1'b0;
        nChecks++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_restart_busy: got %b expected 1", bus.busy); else nPass++;
        nChecks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL b2b_done_pulse: got %b expected 0", bus.done); else nPass++;
        cycles    = 0;
        doneCount = 0;
        while (bus.done !== 1'b1 && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        exp = expQ.pop_front();
        nChecks++;
        if (bus.bcd !== exp || cycles >= LIMIT) $display("[TB] FAIL b2b_second_bcd: got %h expected %h", bus.bcd, exp); else nPass++;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        nChecks++;
        if (doneCount != 0) $display("[TB] FAIL b2b_extra_done: got %0d expected 0", doneCount); else nPass++;
    endtask

    task automatic test_reset_midrun;
        int doneCount;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd200;
        expQ.push_back(refBcd(200));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        nChecks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL midrun_busy: got %b expected 0", bus.busy); else nPass++;
        nChecks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL midrun_done: got %b expected 0", bus.done); else nPass++;
        nChecks++;
        if (bus.bcd !== 12'h000) $display("[TB] FAIL midrun_bcd: got %h expected 000", bus.bcd); else nPass++;
        @(negedge clk);
        rst_n     = 1'b1;
        doneCount = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) doneCount++;
        end
        nChecks++;
        if (doneCount != 0) $display("[TB] FAIL midrun_after: got %0d active cycles expected 0", doneCount); else nPass++;
    endtask

    task automatic test_sweep;
        int cycles;
        int overlap;
        int sweepErrors;
        logic [11:0] exp;
        sweepErrors = 0;
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.start = 1'b1;
            bus.bin   = 8'(v);
            expQ.push_back(refBcd(v));
            @(negedge clk);
            bus.start = 1'b0;
            bus.bin   = 8'($urandom_range(0, 255));
            cycles    = 0;
            overlap   = 0;
            while (bus.done !== 1'b1 && cycles < LIMIT) begin
                @(negedge clk);
                cycles++;
            end
            if (bus.done === 1'b1 && bus.busy === 1'b1) overlap++;
            exp = expQ.pop_front();
            nChecks++;
            if (cycles >= LIMIT || bus.bcd !== exp || overlap != 0) begin
                $display("[TB] FAIL sweep_bcd: bin=%0d got %h expected %h (cycles=%0d)", v, bus.bcd, exp, cycles);
                sweepErrors++;
            end else begin
                nPass++;
            end
            @(negedge clk);
            if (bus.done !== 1'b0) begin
                $display("[TB] FAIL sweep_done_pulse: bin=%0d got %b expected 0", v, bus.done);
                sweepErrors++;
            end
        end
        nChecks++;
        if (sweepErrors != 0) $display("[TB] FAIL sweep_summary: got %0d errors expected 0", sweepErrors); else nPass++;
        nChecks++;
        if (expQ.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", expQ.size()); else nPass++;
    endtask

    initial begin
        test_reset();
        test_values();
        test_back_to_back();
        test_reset_midrun();
        test_sweep();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
